// File: rtl/ela_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ela_frame_reader_if
//  Purpose  : Bundles the result-memory read port and the outgoing pixel
//             stream of ela_frame_reader.
//  Signals  : wen/addr/data_rd  - memory port (read only, 1-cycle latency)
//             out_valid/out_ready/out_data/out_sol/out_eol/out_eof
//                               - raster pixel stream with line/frame marks
//  Modports : master - the frame reader side
//             slave  - memory model plus downstream sink side
//  Revision : 1.0 - initial release
// ============================================================================
interface ela_frame_reader_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sol;
    logic          out_eol;
    logic          out_eof;

    modport master (
        output wen, addr, out_valid, out_data, out_sol, out_eol, out_eof,
        input  data_rd, out_ready
    );

    modport slave (
        input  wen, addr, out_valid, out_data, out_sol, out_eol, out_eof,
        output data_rd, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ela_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ela_frame_reader
//  Purpose  : Reads the IMG_W x IMG_H interpolated frame out of the shared
//             result memory after a start pulse and streams it in raster
//             order with start-of-line, end-of-line and end-of-frame marks.
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous reset, active low
//             start      - single-cycle frame request (ignored unless idle)
//             busy       - frame readout in progress
//             frame_done - one-cycle pulse after the last pixel is accepted
//             bus        - memory read port and pixel stream (master side)
//  Revision : 1.0 - initial release
// ============================================================================
module ela_frame_reader #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 31,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    ela_frame_reader_if.master bus
);

    localparam int             COL_W     = $clog2(IMG_W);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic          eof;
        logic          eol;
        logic          sol;
        logic [DW-1:0] data;
    } entry_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;        // address currently on the memory bus
    logic          r_inflight;    // r_addr is a read whose data arrives next edge
    entry_t        r_fifo0;       // head entry, drives the stream outputs
    entry_t        r_fifo1;
    logic [1:0]    r_count;

    logic          w_pop;
    logic          w_push;
    logic          w_credit_ok;
    logic          w_issue;
    logic [AW-1:0] w_issue_addr;
    entry_t        w_new;

    assign w_pop  = (r_count != 2'd0) && bus.out_ready;
    assign w_push = r_inflight;

    // occupancy + in_flight - pop <= 1, rearranged so nothing underflows
    assign w_credit_ok = ({1'b0, r_count} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop});

    // Tags follow the address that produced the data now on data_rd
    assign w_new.data = bus.data_rd;
    assign w_new.sol  = (r_addr[COL_W-1:0] == '0);
    assign w_new.eol  = (r_addr[COL_W-1:0] == LAST_COL);
    assign w_new.eof  = (r_addr == LAST_ADDR);

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_addr + AW'(1);
        case (r_state)
            S_IDLE: begin
                // FIFO is empty in idle, so address 0 always has credit
                if (start) begin
                    w_issue      = 1'b1;
                    w_issue_addr = '0;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_issue_addr == LAST_ADDR) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // eof is the final pixel, so its acceptance empties the pipe
                if (w_pop && r_fifo0.eof) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_fifo0    <= '0;
            r_fifo1    <= '0;
            r_count    <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr <= w_issue_addr;
            end else if (r_state == S_FIN) begin
                r_addr <= '0;
            end

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_fifo0 <= w_new;
                    end else begin
                        r_fifo1 <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_fifo0 <= r_fifo1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_fifo0 <= w_new;
                    end else begin
                        r_fifo0 <= r_fifo1;
                        r_fifo1 <= w_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.wen       = 1'b0;
    assign bus.addr      = r_addr;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_fifo0.data;
    assign bus.out_sol   = r_fifo0.sol;
    assign bus.out_eol   = r_fifo0.eol;
    assign bus.out_eof   = r_fifo0.eof;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_FIN);

endmodule
`default_nettype wire
